// File: rtl/aib_mac_seq_pkg.sv
// Shared types and helpers for the AIB MAC-side link bring-up sequencer.
package aib_mac_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RSTN   = 3'd1,
    ST_MACRDY = 3'd2,
    ST_XFER   = 3'd3,
    ST_ALIGN  = 3'd4,
    ST_LINKUP = 3'd5,
    ST_FAIL   = 3'd6
  } seq_state_e;

  // One timer serves both the reset hold and every wait-state timeout.
  function automatic int cnt_width(input int rst_cyc, input int to_cyc);
    int m;
    m = (rst_cyc > to_cyc) ? rst_cyc : to_cyc;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

  // States in which the adapter is out of reset and near-side MAC is ready.
  function automatic logic is_active(input seq_state_e s);
    return (s == ST_MACRDY) || (s == ST_XFER) || (s == ST_ALIGN) || (s == ST_LINKUP);
  endfunction

endpackage

// File: rtl/aib_mac_chnl_seq.sv
// One channel of the link bring-up sequencer: FSM, saturating timer and
// registered Moore outputs.
module aib_mac_chnl_seq
  import aib_mac_seq_pkg::*;
#(
  parameter int RST_CYC = 16,
  parameter int TO_CYC  = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  logic       restart,
  input  logic       fs_mac_rdy,
  input  logic       tx_en,
  input  logic       rx_en,
  input  logic       align_done,
  output logic       adapter_rstn,
  output logic       mac_rdy,
  output logic       link_up,
  output logic       link_fail,
  output logic [2:0] state
);

  localparam int CW = cnt_width(RST_CYC, TO_CYC);
  localparam logic [CW-1:0] RST_LAST = CW'(RST_CYC - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TO_CYC - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  seq_state_e    cur;
  seq_state_e    nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] nxt_cnt;
  logic          xfer_ok;
  logic          timeout;

  assign xfer_ok = tx_en & rx_en;
  assign timeout = (cnt == TO_LAST);
  assign state   = cur;

  // Far-side drop outranks every other exit; losing go outranks everything.
  always_comb begin
    nxt = cur;
    case (cur)
      ST_IDLE:   if (go) nxt = ST_RSTN;
      ST_RSTN:   if (cnt == RST_LAST) nxt = ST_MACRDY;
      ST_MACRDY: begin
        if (fs_mac_rdy)   nxt = ST_XFER;
        else if (timeout) nxt = ST_FAIL;
      end
      ST_XFER: begin
        if (!fs_mac_rdy)  nxt = ST_IDLE;
        else if (xfer_ok) nxt = ST_ALIGN;
        else if (timeout) nxt = ST_FAIL;
      end
      ST_ALIGN: begin
        if (!fs_mac_rdy)     nxt = ST_IDLE;
        else if (align_done) nxt = ST_LINKUP;
        else if (timeout)    nxt = ST_FAIL;
      end
      ST_LINKUP: begin
        if (!fs_mac_rdy)                nxt = ST_IDLE;
        else if (!(xfer_ok && align_done)) nxt = ST_XFER;
      end
      ST_FAIL:   if (restart) nxt = ST_IDLE;
      default:   nxt = ST_IDLE;
    endcase
    if (!go) nxt = ST_IDLE;
  end

  always_comb begin
    nxt_cnt = cnt;
    if (nxt != cur)          nxt_cnt = '0;
    else if (cnt != CNT_MAX) nxt_cnt = cnt + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur          <= ST_IDLE;
      cnt          <= '0;
      adapter_rstn <= 1'b0;
      mac_rdy      <= 1'b0;
      link_up      <= 1'b0;
      link_fail    <= 1'b0;
    end else begin
      cur          <= nxt;
      cnt          <= nxt_cnt;
      adapter_rstn <= is_active(nxt);
      mac_rdy      <= is_active(nxt);
      link_up      <= (nxt == ST_LINKUP);
      link_fail    <= (nxt == ST_FAIL);
    end
  end

endmodule

// File: rtl/aib_mac_link_seq.sv
// MAC-side AIB link bring-up: one independent sequencer per channel plus a
// registered "every enabled channel is up" summary.
module aib_mac_link_seq
  import aib_mac_seq_pkg::*;
#(
  parameter int TOTAL_CHNL_NUM = 24,
  parameter int RST_CYC        = 16,
  parameter int TO_CYC         = 4096
) (
  input  logic                      i_osc_clk,
  input  logic                      i_m_power_on_reset,
  input  logic                      i_conf_done,
  input  logic                      i_m_device_detect,
  input  logic [TOTAL_CHNL_NUM-1:0] i_chnl_en,
  input  logic [TOTAL_CHNL_NUM-1:0] i_chnl_restart,
  input  logic [TOTAL_CHNL_NUM-1:0] i_fs_mac_rdy,
  input  logic [TOTAL_CHNL_NUM-1:0] i_tx_transfer_en,
  input  logic [TOTAL_CHNL_NUM-1:0] i_rx_transfer_en,
  input  logic [TOTAL_CHNL_NUM-1:0] i_rx_align_done,
  output logic [TOTAL_CHNL_NUM-1:0] o_ns_adapter_rstn,
  output logic [TOTAL_CHNL_NUM-1:0] o_ns_mac_rdy,
  output logic [TOTAL_CHNL_NUM-1:0] o_link_up,
  output logic [TOTAL_CHNL_NUM-1:0] o_link_fail,
  output logic                      o_all_link_up
);

  logic                      go_global;
  logic [2:0]                chnl_state [TOTAL_CHNL_NUM];
  logic [TOTAL_CHNL_NUM-1:0] chnl_up;

  assign go_global = i_conf_done & i_m_device_detect;

  for (genvar c = 0; c < TOTAL_CHNL_NUM; c++) begin : g_chnl
    aib_mac_chnl_seq #(
      .RST_CYC (RST_CYC),
      .TO_CYC  (TO_CYC)
    ) u_chnl (
      .clk          (i_osc_clk),
      .rst          (i_m_power_on_reset),
      .go           (go_global & i_chnl_en[c]),
      .restart      (i_chnl_restart[c]),
      .fs_mac_rdy   (i_fs_mac_rdy[c]),
      .tx_en        (i_tx_transfer_en[c]),
      .rx_en        (i_rx_transfer_en[c]),
      .align_done   (i_rx_align_done[c]),
      .adapter_rstn (o_ns_adapter_rstn[c]),
      .mac_rdy      (o_ns_mac_rdy[c]),
      .link_up      (o_link_up[c]),
      .link_fail    (o_link_fail[c]),
      .state        (chnl_state[c])
    );
    assign chnl_up[c] = (chnl_state[c] == ST_LINKUP);
  end

  // Disabled channels do not hold the summary low, but an empty mask never reports up.
  always_ff @(posedge i_osc_clk or posedge i_m_power_on_reset) begin
    if (i_m_power_on_reset) o_all_link_up <= 1'b0;
    else                    o_all_link_up <= (&(chnl_up | ~i_chnl_en)) & (|i_chnl_en);
  end

endmodule
